// File: rtl/serial_adder_n_pkg.sv
// serial_adder_n_pkg: shared FSM state type and default operand width
package serial_adder_n_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/serial_adder_n_if.sv
// serial_adder_n_if: request/result bundle between a requester and the serial adder
interface serial_adder_n_if #(parameter int WIDTH = serial_adder_n_pkg::WIDTH_DEF);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    modport master (output start, sub, a, b, input busy, done, sum, carry_out, overflow);
    modport slave  (input start, sub, a, b, output busy, done, sum, carry_out, overflow);
endinterface

// File: rtl/full_adder_bit.sv
// full_adder_bit: single-bit full adder used as the serial datapath core
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: LSB-first bit-serial add/subtract, one bit per clock
module serial_adder_n import serial_adder_n_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    serial_adder_n_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t           state, nxt;
    logic [WIDTH-1:0] ra, rb, rs, sum_q;
    logic [CW-1:0]    cnt;
    logic             cy, s, cout, co_q, ov_q, last;
    assign last = cnt == CW'(WIDTH - 1);
    full_adder_bit u_fa (.a(ra[0]), .b(rb[0]), .cin(cy), .s(s), .cout(cout));
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = state == IDLE ? (bus.start ? RUN : IDLE)
            : state == RUN  ? (last ? DONE : RUN)
            : IDLE;
    end
    // subtraction is a + ~b + 1, the +1 entering through the initial carry
    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum_q <= '0;
            co_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ra  <= bus.a;
            rb  <= bus.sub ? ~bus.b : bus.b;
            cy  <= bus.sub;
            cnt <= '0;
        end else if (state == RUN) begin
            rs  <= {s, rs[WIDTH-1:1]};
            ra  <= ra >> 1;
            rb  <= rb >> 1;
            cy  <= cout;
            cnt <= cnt + CW'(1);
            if (last) begin
                sum_q <= {s, rs[WIDTH-1:1]};
                co_q  <= cout;
                ov_q  <= cy ^ cout;
            end
        end
    end
    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  WIDTH  operand A, unsigned/two's-complement agnostic, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 sum  output  WIDTH  result, held stable from done until next accepted start.
REQ-011 carry_out  output  1  final carry; in sub mode 1 = no borrow.
REQ-012 overflow  output  1  signed overflow of the WIDTH-bit result.

Function
REQ-013 The block SHALL add bit-serially, LSB first, one bit per clock, using a 1-bit full adder and a carry flip-flop.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 IDLE -> RUN when start=1 at a rising edge; that edge loads shift registers with a and (sub ? ~b : b), carry FF with sub, bit counter with 0.
REQ-016 In RUN, each edge SHALL shift the full-adder sum bit into the MSB of the result shift register, shift both operand registers right by one, update carry FF, increment counter.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1; RUN SHALL last exactly WIDTH cycles.
REQ-018 DONE -> IDLE unconditionally on the next edge; done=1 only in DONE.
REQ-019 Latency: start sampled at edge e0 -> done high in the cycle after edge eWIDTH (WIDTH+1 edges start-to-done inclusive of e0).
REQ-020 busy SHALL be 1 exactly in RUN; done and busy never both 1.
REQ-021 start while in RUN or DONE SHALL be ignored, with no effect on the operation in progress; back-to-back operations SHALL have start accepted in the first IDLE cycle after DONE.
REQ-022 carry_out SHALL equal the carry out of bit WIDTH-1.
REQ-023 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 sum, carry_out, overflow SHALL update only when DONE is entered, holding through DONE and IDLE until the next operation completes.
REQ-025 The counter SHALL be $clog2(WIDTH)+1 bits wide; no wrap occurs within a legal operation.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, clear the counter and carry FF, and clear the operand registers.
REQ-027 rst SHALL take priority over start and over any in-flight RUN/DONE; the aborted operation produces no done pulse.
REQ-028 start asserted together with rst SHALL be ignored; the first accepted start is in a cycle with rst=0.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-030 One sub-module, full_adder_bit (inputs a, b, cin; outputs s, cout), SHALL be instantiated once for the serial datapath.

Verification (WIDTH=8)
REQ-031 sub=0, a=0xFF, b=0x01 -> after 9 edges done=1, sum=0x00, carry_out=1, overflow=0.
REQ-032 sub=0, a=0x7F, b=0x01 -> sum=0x80, carry_out=0, overflow=1.
REQ-033 sub=1, a=0x05, b=0x07 -> sum=0xFE, carry_out=0, overflow=0; sub=1, a=0x80, b=0x01 -> sum=0x7F, overflow=1.
REQ-034 start re-asserted with new operands during RUN -> ignored; result matches the first operands; busy high exactly 8 cycles.
REQ-035 rst pulsed at the 4th RUN cycle -> next cycle IDLE, all outputs 0, no done; a following op 0x12+0x34 -> 0x46.
REQ-036 Back-to-back: start held high continuously -> done pulses every 10 cycles, each with the operands sampled at that start.
